alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits (power of two, 8..32).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request strobe, one op per accepted cycle.
REQ-005 op_en  input  15  one-hot op enables from opcode decoder, bit0..14 = ADD,SUB,MUL,DIV,MOD,MAX,MIN,NOT,NAND,XNOR,SHL,SHRL,ROL,ROR,SLT.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 busy  output  1  high while an op is in flight; start ignored when high.
REQ-009 done  output  1  one-cycle pulse, result/flags valid.
REQ-010 result  output  WIDTH  registered result, held until next accepted start completes.
REQ-011 zero  output  1  result == 0, registered with result.
REQ-012 err  output  1  illegal op_en or divide/mod by zero, registered with result.

Function
REQ-013 Start accepted only when start=1 and busy=0; a, b, op_en captured that edge; later input changes have no effect.
REQ-014 FSM states IDLE, ITER, DONE; IDLE->DONE for single-cycle ops, IDLE->ITER for MUL/DIV/MOD, ITER->DONE when iteration counter reaches WIDTH, DONE->IDLE unconditionally.
REQ-015 busy=1 in ITER and DONE; done=1 only in DONE; start asserted in DONE is dropped.
REQ-016 Single-cycle ops: start accepted cycle 0 -> done=1 and result valid cycle 1.
REQ-017 MUL/DIV/MOD: start cycle 0 -> ITER cycles 1..WIDTH -> done cycle WIDTH+1; one partial step per ITER cycle, counter log2(WIDTH)+1 bits.
REQ-018 ADD/SUB: a+b, a-b modulo 2^WIDTH; carry/borrow discarded.
REQ-019 MUL: low WIDTH bits of a*b via shift-add.
REQ-020 DIV: floor(a/b); MOD: a mod b; restoring division, shared datapath.
REQ-021 b==0 for DIV/MOD: no ITER; done at cycle 1, err=1, DIV result all ones, MOD result = a.
REQ-022 MAX/MIN/SLT unsigned compare; SLT result = 1 if a<b else 0 (zero-extended).
REQ-023 NOT ~a; NAND ~(a&b); XNOR ~(a^b).
REQ-024 SHL/SHRL logical shifts of a by b mod WIDTH, zero fill; ROL/ROR rotate a by b mod WIDTH.
REQ-025 op_en zero or more than one bit set: treated as illegal, done at cycle 1, result=0, zero=1, err=1.
REQ-026 result, zero, err update only in transition into DONE; stable otherwise.

Reset
REQ-027 rst_n low at any time, including mid-ITER: state IDLE, busy=0, done=0, result=0, zero=0, err=0, counter=0, in-flight op discarded.
REQ-028 First start accepted on first rising edge with rst_n high.

Verification (WIDTH=16)
REQ-029 ADD a=0xFFFF b=0x0002, start -> cycle 1 done=1 result=0x0001 zero=0 err=0.
REQ-030 MUL a=0x0123 b=0x0010 -> busy cycles 1..17, done cycle 17 result=0x1230; DIV a=100 b=7 -> result=14; MOD -> result=2.
REQ-031 DIV a=0x0005 b=0 -> done cycle 1 result=0xFFFF err=1; MOD same operands -> result=0x0005 err=1.
REQ-032 ROR a=0x0001 b=0x0011 -> result=0x8000; SHL a=0x8001 b=1 -> result=0x0002; SLT a=3 b=5 -> result=0x0001.
REQ-033 op_en=0x0003 with start -> done cycle 1 result=0 zero=1 err=1; second start during MUL ITER ignored, MUL result unchanged.
REQ-034 rst_n low at ITER cycle 5 of DIV -> busy=0, done=0, result=0 immediately; no done pulse follows; new ADD after release completes normally.

Source files
------------

// File: rtl/alu_if.sv
// alu_if: request/response bundle between an issuing block and alu_exec_unit.
//   master : drives start, op_en, a, b; observes busy, done, result, zero, err
//   slave  : the execution unit side (directions mirrored)
//   start  : request strobe, taken only while busy is low
//   op_en  : one-hot op select, bit0..14 = ADD,SUB,MUL,DIV,MOD,MAX,MIN,NOT,NAND,XNOR,
//            SHL,SHRL,ROL,ROR,SLT
//   a, b   : unsigned operands
//   busy   : op in flight; done: one-cycle result-valid pulse
//   result, zero, err : registered outputs, held until the next op completes
interface alu_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             start;
    logic [14:0]      op_en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;

    modport master (
        output start, op_en, a, b,
        input  busy, done, result, zero, err
    );

    modport slave (
        input  start, op_en, a, b,
        output busy, done, result, zero, err
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle ALU. Single-cycle ops finish one cycle after the accepting
// edge; MUL (shift-add) and DIV/MOD (restoring division, shared datapath) spend WIDTH
// iteration cycles first.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_if slave (start/op_en/a/b in, busy/done/result/zero/err out)
module alu_exec_unit #(
    parameter int unsigned WIDTH = 16
) (
    input logic  clk,
    input logic  rst_n,
    alu_if.slave bus
);
    localparam int unsigned ShW  = $clog2(WIDTH);
    localparam int unsigned CntW = ShW + 1;

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;
    typedef enum logic [1:0] {KindMul, KindDiv, KindMod} kind_e;

    state_e           state_q, state_d;
    kind_e            kind_q, kind_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;   // MUL: shifted multiplicand; DIV/MOD: dividend/quotient
    logic [WIDTH-1:0] opb_q, opb_d;   // MUL: shifted multiplier;   DIV/MOD: divisor
    logic [WIDTH-1:0] acc_q, acc_d;   // MUL: product;              DIV/MOD: remainder
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic             accept;
    logic [WIDTH-1:0] sc_res;
    logic [ShW-1:0]   sh;
    logic [2*WIDTH-1:0] dbl_l, dbl_r;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    assign accept = bus.start && (state_q == StIdle);

    // Single-cycle ops, evaluated straight from the inputs on the accepting edge.
    always_comb begin
        sc_res = '0;
        sh     = bus.b[ShW-1:0];
        dbl_l  = {bus.a, bus.a} << sh;
        dbl_r  = {bus.a, bus.a} >> sh;
        if ($onehot(bus.op_en)) begin
            unique case (1'b1)
                bus.op_en[0]:  sc_res = bus.a + bus.b;
                bus.op_en[1]:  sc_res = bus.a - bus.b;
                bus.op_en[5]:  sc_res = (bus.a > bus.b) ? bus.a : bus.b;
                bus.op_en[6]:  sc_res = (bus.a < bus.b) ? bus.a : bus.b;
                bus.op_en[7]:  sc_res = ~bus.a;
                bus.op_en[8]:  sc_res = ~(bus.a & bus.b);
                bus.op_en[9]:  sc_res = ~(bus.a ^ bus.b);
                bus.op_en[10]: sc_res = bus.a << sh;
                bus.op_en[11]: sc_res = bus.a >> sh;
                bus.op_en[12]: sc_res = dbl_l[2*WIDTH-1:WIDTH];
                bus.op_en[13]: sc_res = dbl_r[WIDTH-1:0];
                bus.op_en[14]: sc_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
                default:       sc_res = '0;  // MUL/DIV/MOD go through the iterative path
            endcase
        end
    end

    // One iteration step of each multi-cycle datapath.
    always_comb begin
        mul_acc = acc_q + (opb_q[0] ? opa_q : '0);
        rem_sh  = {acc_q, opa_q[WIDTH-1]};
        rem_ge  = rem_sh >= {1'b0, opb_q};
        // When rem_ge holds the difference is below the divisor, so WIDTH bits suffice.
        rem_nx  = rem_ge ? (rem_sh[WIDTH-1:0] - opb_q) : rem_sh[WIDTH-1:0];
        quo_nx  = {opa_q[WIDTH-2:0], rem_ge};
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!$onehot(bus.op_en)) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = StDone;
                    end else if (bus.op_en[2]) begin
                        opa_d   = bus.a;
                        opb_d   = bus.b;
                        acc_d   = '0;
                        cnt_d   = '0;
                        kind_d  = KindMul;
                        state_d = StIter;
                    end else if (bus.op_en[3] || bus.op_en[4]) begin
                        if (bus.b == '0) begin
                            result_d = bus.op_en[3] ? '1 : bus.a;
                            err_d    = 1'b1;
                            state_d  = StDone;
                        end else begin
                            opa_d   = bus.a;
                            opb_d   = bus.b;
                            acc_d   = '0;
                            cnt_d   = '0;
                            kind_d  = bus.op_en[3] ? KindDiv : KindMod;
                            state_d = StIter;
                        end
                    end else begin
                        result_d = sc_res;
                        err_d    = 1'b0;
                        state_d  = StDone;
                    end
                end
            end
            StIter: begin
                cnt_d = cnt_q + 1'b1;
                if (kind_q == KindMul) begin
                    acc_d = mul_acc;
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end else begin
                    acc_d = rem_nx;
                    opa_d = quo_nx;
                end
                if (cnt_d == CntW'(WIDTH)) begin
                    unique case (kind_q)
                        KindMul: result_d = mul_acc;
                        KindDiv: result_d = quo_nx;
                        default: result_d = rem_nx;
                    endcase
                    err_d   = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;  // a start seen here is dropped
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StDone && state_q != StDone) begin
            zero_d = (result_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            kind_q   <= KindMul;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = (state_q == StDone);
    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed plus model-driven checks of alu_exec_unit at WIDTH=16.
module tb_alu_exec_unit;
    localparam int unsigned W = 16;

    typedef struct {
        string       tag;
        logic [15:0] res;
        logic        zero;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    alu_if #(.WIDTH(W)) bus_if ();

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;
    logic [15:0] prev_res = 16'h0;

    task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference ALU built from native operators.
    function automatic logic [15:0] model(input int idx, input logic [15:0] x,
                                          input logic [15:0] y);
        logic [3:0] s;
        s = y[3:0];
        case (idx)
            0:  return x + y;
            1:  return x - y;
            2:  return x * y;
            3:  return (y == 0) ? 16'hFFFF : x / y;
            4:  return (y == 0) ? x : x % y;
            5:  return (x > y) ? x : y;
            6:  return (x < y) ? x : y;
            7:  return ~x;
            8:  return ~(x & y);
            9:  return ~(x ^ y);
            10: return x << s;
            11: return x >> s;
            12: return (x << s) | (x >> (16 - int'(s)));
            13: return (x >> s) | (x << (16 - int'(s)));
            default: return (x < y) ? 16'h1 : 16'h0;
        endcase
    endfunction

    // Issue one op, push its expectation, wait (bounded) for done, then compare.
    // poke: cycle index at which a spurious start is raised for one cycle (0 = none).
    task automatic run_op(input string tag, input logic [14:0] oe, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] er, input logic ee,
                          input int lat, input int poke);
        exp_t e;
        int   c;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op_en = oe;
        bus_if.a     = x;
        bus_if.b     = y;
        e.tag  = tag;
        e.res  = er;
        e.zero = (er == 16'h0);
        e.err  = ee;
        e.lat  = lat;
        sb.push_back(e);
        c = 0;
        do begin
            @(negedge clk);
            c++;
            // Scramble inputs after acceptance; the captured op must be unaffected.
            bus_if.start = (c == poke);
            bus_if.op_en = 15'h0001;
            bus_if.a     = 16'($urandom);
            bus_if.b     = 16'($urandom);
            if (c == 1) begin
                chk1({tag, "_busy"}, bus_if.busy, 1'b1);
                if (lat > 1) chk16({tag, "_held"}, bus_if.result, prev_res);
            end
        end while (!bus_if.done && c < 100);
        e = sb.pop_front();
        chk_int({e.tag, "_lat"}, c, e.lat);
        chk16({e.tag, "_res"}, bus_if.result, e.res);
        chk1({e.tag, "_zero"}, bus_if.zero, e.zero);
        chk1({e.tag, "_err"}, bus_if.err, e.err);
        prev_res = e.res;
        @(negedge clk);
        bus_if.start = 1'b0;
        chk1({e.tag, "_pulse"}, bus_if.done, 1'b0);
        chk1({e.tag, "_idle"}, bus_if.busy, 1'b0);
        chk16({e.tag, "_stable"}, bus_if.result, e.res);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int          c;
        logic [15:0] x, y, er;
        bus_if.start = 1'b0;
        bus_if.op_en = 15'h0;
        bus_if.a     = 16'h0;
        bus_if.b     = 16'h0;
        repeat (3) @(negedge clk);
        chk1("rst_busy", bus_if.busy, 1'b0);
        chk1("rst_done", bus_if.done, 1'b0);
        chk16("rst_result", bus_if.result, 16'h0);
        chk1("rst_zero", bus_if.zero, 1'b0);
        chk1("rst_err", bus_if.err, 1'b0);
        rst_n = 1'b1;

        run_op("add_wrap", 15'h0001, 16'hFFFF, 16'h0002, 16'h0001, 1'b0, 1, 0);
        run_op("mul", 15'h0004, 16'h0123, 16'h0010, 16'h1230, 1'b0, 17, 0);
        run_op("div", 15'h0008, 16'd100, 16'd7, 16'd14, 1'b0, 17, 0);
        run_op("mod", 15'h0010, 16'd100, 16'd7, 16'd2, 1'b0, 17, 0);
        run_op("div0", 15'h0008, 16'h0005, 16'h0000, 16'hFFFF, 1'b1, 1, 0);
        run_op("mod0", 15'h0010, 16'h0005, 16'h0000, 16'h0005, 1'b1, 1, 0);
        run_op("ror", 15'h2000, 16'h0001, 16'h0011, 16'h8000, 1'b0, 1, 0);
        run_op("shl", 15'h0400, 16'h8001, 16'h0001, 16'h0002, 1'b0, 1, 0);
        run_op("slt", 15'h4000, 16'd3, 16'd5, 16'h0001, 1'b0, 1, 0);
        run_op("sub_zero", 15'h0002, 16'd5, 16'd5, 16'h0000, 1'b0, 1, 0);
        run_op("ill_two", 15'h0003, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1, 0);
        run_op("ill_none", 15'h0000, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1, 0);
        run_op("mul_poke", 15'h0004, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 17, 3);
        run_op("add_poke_done", 15'h0001, 16'h1000, 16'h0234, 16'h1234, 1'b0, 1, 1);

        for (int idx = 0; idx < 15; idx++) begin
            for (int k = 0; k < 2; k++) begin
                x  = 16'($urandom);
                y  = (k == 1 && (idx == 3 || idx == 4)) ? 16'($urandom_range(1, 300))
                                                        : 16'($urandom);
                er = model(idx, x, y);
                run_op($sformatf("rnd_op%0d_%0d", idx, k), 15'(1 << idx), x, y, er,
                       1'b0, ((idx >= 2 && idx <= 4) && y != 0) ? 17 : 1, 0);
            end
        end

        // Reset in the middle of a division: everything clears at once, no done follows.
        run_op("pre_rst", 15'h0001, 16'h0040, 16'h0002, 16'h0042, 1'b0, 1, 0);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op_en = 15'h0008;
        bus_if.a     = 16'd100;
        bus_if.b     = 16'd7;
        repeat (5) @(negedge clk);
        bus_if.start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk1("midrst_busy", bus_if.busy, 1'b0);
        chk1("midrst_done", bus_if.done, 1'b0);
        chk16("midrst_result", bus_if.result, 16'h0);
        chk1("midrst_err", bus_if.err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        c = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.done || bus_if.busy) c++;
        end
        chk_int("midrst_quiet", c, 0);
        prev_res = 16'h0;
        run_op("post_rst_add", 15'h0001, 16'h0102, 16'h0304, 16'h0406, 1'b0, 1, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
